// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Imported by pc_gen_unit.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } pc_state_e;

    localparam int          PC_ALIGN_BITS        = 2;
    localparam logic [1:0]  PC_ALIGN_MASK        = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_INC          = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and its neighbours.
// The neighbours are IMEM, the hazard unit, the EX stage and trap logic.
interface pc_gen_if #(
    parameter int XLEN    = 32,
    parameter int EPOCH_W = 2
);
    logic               pc_en;
    logic               fetch_ready;
    logic               br_taken;
    logic [XLEN-1:0]    br_target;
    logic               trap_req;
    logic [XLEN-1:0]    trap_vec;

    logic               fetch_valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [EPOCH_W-1:0] epoch;
    logic               redirect_pending;
    logic               misalign_err;

    // master is the PC generator itself; slave is the surrounding pipeline
    modport master (
        input  pc_en, fetch_ready, br_taken, br_target, trap_req, trap_vec,
        output fetch_valid, pc, pc_plus4, epoch, redirect_pending, misalign_err
    );

    modport slave (
        output pc_en, fetch_ready, br_taken, br_target, trap_req, trap_vec,
        input  fetch_valid, pc, pc_plus4, epoch, redirect_pending, misalign_err
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry buffer that holds a redirect while the PC is not allowed to move.
// A capture always overwrites the entry; it wins over a clear in the same cycle.
module pc_redirect_buf #(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_capture,
    input  logic          i_clear,
    input  logic [AW-1:0] i_target,
    input  logic          i_misalign,
    output logic          o_valid,
    output logic [AW-1:0] o_target,
    output logic          o_misalign
);
    logic          r_valid;
    logic [AW-1:0] r_target;
    logic          r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: payload is not reset on purpose; r_valid qualifies it, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_target   <= i_target;
            r_misalign <= i_misalign;
        end
    end

    assign o_valid    = r_valid;
    assign o_target   = r_target;
    assign o_misalign = r_misalign;
endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator: boot/run/hold FSM, PC register, epoch counter
// and next-PC selection (trap > branch > buffered redirect > sequential).
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              INC          = DEFAULT_INC,
    parameter int              EPOCH_W      = 2
) (
    input logic      clk,
    input logic      reset,
    pc_gen_if.master bus
);
    localparam int AW = XLEN - PC_ALIGN_BITS;

    pc_state_e          r_state;
    pc_state_e          w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_misalign;

    logic               w_fetch_valid;
    logic               w_can_move;
    logic               w_advance;
    logic               w_live;
    logic [AW-1:0]      w_live_tgt;
    logic               w_live_mis;
    logic               w_pend;
    logic [AW-1:0]      w_pend_tgt;
    logic               w_pend_mis;
    logic               w_redirect;
    logic [AW-1:0]      w_redir_tgt;
    logic               w_redir_mis;
    logic [XLEN-1:0]    w_pc_plus;
    logic               w_unused_trap_lsbs;

    // The request must stay stable while offered and not accepted.
    assign w_can_move = bus.pc_en & (~w_fetch_valid | bus.fetch_ready);
    assign w_advance  = (r_state != S_BOOT) & w_can_move;

    assign w_live     = bus.trap_req | bus.br_taken;
    assign w_live_tgt = bus.trap_req ? bus.trap_vec[XLEN-1:PC_ALIGN_BITS]
                                     : bus.br_target[XLEN-1:PC_ALIGN_BITS];
    assign w_live_mis = ~bus.trap_req & bus.br_taken
                      & (|(bus.br_target[PC_ALIGN_BITS-1:0] & PC_ALIGN_MASK));
    assign w_unused_trap_lsbs = ^bus.trap_vec[PC_ALIGN_BITS-1:0];

    assign w_redirect  = w_advance & (w_live | w_pend);
    assign w_redir_tgt = w_live ? w_live_tgt : w_pend_tgt;
    assign w_redir_mis = w_live ? w_live_mis : w_pend_mis;
    assign w_pc_plus   = r_pc + XLEN'(INC);

    pc_redirect_buf #(
        .AW (AW)
    ) u_redirect_buf (
        .clk        (clk),
        .reset      (reset),
        .i_capture  (w_live & ~w_advance),
        .i_clear    (w_redirect),
        .i_target   (w_live_tgt),
        .i_misalign (w_live_mis),
        .o_valid    (w_pend),
        .o_target   (w_pend_tgt),
        .o_misalign (w_pend_mis)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_live && !w_advance) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_advance) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_fetch_valid = 1'b0;
        case (r_state)
            S_RUN, S_HOLD: w_fetch_valid = 1'b1;
            default:       w_fetch_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_epoch    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect & w_redir_mis;
            if (w_advance) begin
                r_pc <= w_redirect ? {w_redir_tgt, {PC_ALIGN_BITS{1'b0}}} : w_pc_plus;
            end
            if (w_redirect) begin
                r_epoch <= r_epoch + EPOCH_W'(1);
            end
        end
    end

    assign bus.fetch_valid      = w_fetch_valid;
    assign bus.pc               = r_pc;
    assign bus.pc_plus4         = w_pc_plus;
    assign bus.epoch            = r_epoch;
    assign bus.redirect_pending = w_pend;
    assign bus.misalign_err     = r_misalign;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios with literal expectations plus a
// transaction-level reference model compared on every falling edge.
module tb_pc_gen_unit;
    localparam int XLEN    = 32;
    localparam int EPOCH_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) bus ();

    pc_gen_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0),
        .INC          (4),
        .EPOCH_W      (EPOCH_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: what the fetch stage should look like after each edge.
    longint unsigned m_pc;
    int              m_epoch;
    bit              m_valid, m_pend, m_pend_mis, m_mis;
    longint unsigned m_pend_tgt;

    always @(posedge clk) begin
        longint unsigned tgt;
        bit live, live_mis, move;
        if (reset) begin
            m_pc = 0; m_valid = 0; m_epoch = 0; m_pend = 0; m_mis = 0;
        end else begin
            live     = bus.trap_req || bus.br_taken;
            tgt      = bus.trap_req ? (longint'(bus.trap_vec) / 4) * 4
                                    : (longint'(bus.br_target) / 4) * 4;
            live_mis = !bus.trap_req && bus.br_taken && (bus.br_target % 4 != 0);
            move     = m_valid && bus.pc_en && bus.fetch_ready;
            m_mis    = 0;
            if (move && live) begin
                m_pc = tgt; m_epoch = (m_epoch + 1) % 4; m_mis = live_mis; m_pend = 0;
            end else if (move && m_pend) begin
                m_pc = m_pend_tgt; m_epoch = (m_epoch + 1) % 4; m_mis = m_pend_mis; m_pend = 0;
            end else if (move) begin
                m_pc = (m_pc + 4) % (64'd1 << XLEN);
            end else if (live) begin
                m_pend = 1; m_pend_tgt = tgt; m_pend_mis = live_mis;
            end
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc",       64'(bus.pc),               m_pc);
            check("model_pc_plus4", 64'(bus.pc_plus4),         (m_pc + 4) % (64'd1 << XLEN));
            check("model_valid",    64'(bus.fetch_valid),      64'(m_valid));
            check("model_epoch",    64'(bus.epoch),            64'(m_epoch));
            check("model_pending",  64'(bus.redirect_pending), 64'(m_pend));
            check("model_misalign", 64'(bus.misalign_err),     64'(m_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic en, input logic [31:0] tgt);
        bus.br_taken  = en;
        bus.br_target = tgt;
    endtask

    initial begin
        reset = 1'b1;
        bus.pc_en = 1'b1; bus.fetch_ready = 1'b1;
        bus.br_taken = 1'b0; bus.br_target = '0;
        bus.trap_req = 1'b0; bus.trap_vec = '0;

        // Boot sequence
        tick(); cmp_en = 1'b1; tick(); tick();
        check("rst_pc", 64'(bus.pc), 64'h0);
        check("rst_valid", 64'(bus.fetch_valid), 64'h0);
        check("rst_epoch", 64'(bus.epoch), 64'h0);
        reset = 1'b0;
        tick(); check("boot_pc", 64'(bus.pc), 64'h0); check("boot_valid", 64'(bus.fetch_valid), 64'h1);
        tick(); check("seq_pc4", 64'(bus.pc), 64'h4);
        tick(); check("seq_pc8", 64'(bus.pc), 64'h8);
        tick(); check("seq_pcC", 64'(bus.pc), 64'hC);
        tick(); check("seq_pc10", 64'(bus.pc), 64'h10);

        // Back-pressure from IMEM
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 64'(bus.pc), 64'h10);
            check("stall_valid", 64'(bus.fetch_valid), 64'h1);
        end
        bus.fetch_ready = 1'b1;
        tick(); check("resume_pc", 64'(bus.pc), 64'h14);
        tick(); tick(); tick(); check("pc20", 64'(bus.pc), 64'h20);

        // Branch during hazard stall is buffered
        bus.pc_en = 1'b0; set_br(1'b1, 32'h80);
        tick(); check("buf_pending", 64'(bus.redirect_pending), 64'h1); check("buf_pc", 64'(bus.pc), 64'h20);
        set_br(1'b0, 32'h0); bus.pc_en = 1'b1;
        tick(); check("buf_apply_pc", 64'(bus.pc), 64'h80);
        check("buf_apply_epoch", 64'(bus.epoch), 64'h1);
        check("buf_apply_pending", 64'(bus.redirect_pending), 64'h0);

        // Trap beats branch, low bits forced to zero
        bus.trap_req = 1'b1; bus.trap_vec = 32'h103; set_br(1'b1, 32'h40);
        tick(); check("trap_pc", 64'(bus.pc), 64'h100); check("trap_epoch", 64'(bus.epoch), 64'h2);
        check("trap_mis", 64'(bus.misalign_err), 64'h0);
        bus.trap_req = 1'b0; set_br(1'b0, 32'h0);

        // Misaligned branch target, then epoch wrap
        set_br(1'b1, 32'h46);
        tick(); check("mis_pc", 64'(bus.pc), 64'h44); check("mis_pulse", 64'(bus.misalign_err), 64'h1);
        check("mis_epoch", 64'(bus.epoch), 64'h3);
        set_br(1'b0, 32'h0);
        tick(); check("mis_clear", 64'(bus.misalign_err), 64'h0); check("mis_seq_pc", 64'(bus.pc), 64'h48);
        set_br(1'b1, 32'h200);
        tick(); check("epoch_wrap", 64'(bus.epoch), 64'h0); check("wrap_pc", 64'(bus.pc), 64'h200);

        // PC wraps past the top of the address space
        set_br(1'b1, 32'hFFFF_FFF8);
        tick(); set_br(1'b0, 32'h0);
        tick(); check("top_pc", 64'(bus.pc), 64'hFFFF_FFFC); check("top_plus4", 64'(bus.pc_plus4), 64'h0);
        tick(); check("wrap_zero", 64'(bus.pc), 64'h0);

        // Newer buffered redirect overwrites older; buffered misalign is reported
        bus.pc_en = 1'b0; set_br(1'b1, 32'h301);
        tick(); set_br(1'b1, 32'h502);
        tick(); set_br(1'b0, 32'h0); bus.pc_en = 1'b1;
        tick(); check("ovr_pc", 64'(bus.pc), 64'h500); check("ovr_mis", 64'(bus.misalign_err), 64'h1);
        check("ovr_epoch", 64'(bus.epoch), 64'h2);

        // Trap over branch while IMEM blocks
        bus.fetch_ready = 1'b0; bus.trap_req = 1'b1; bus.trap_vec = 32'h700; set_br(1'b1, 32'h800);
        tick(); bus.trap_req = 1'b0; set_br(1'b0, 32'h0);
        check("blk_pc", 64'(bus.pc), 64'h500);
        bus.fetch_ready = 1'b1;
        tick(); check("blk_trap_pc", 64'(bus.pc), 64'h700);

        // Live redirect wins over buffered one, single epoch step
        bus.pc_en = 1'b0; set_br(1'b1, 32'h900);
        tick(); bus.pc_en = 1'b1; set_br(1'b1, 32'hA00);
        tick(); set_br(1'b0, 32'h0);
        check("live_pc", 64'(bus.pc), 64'hA00); check("live_epoch", 64'(bus.epoch), 64'h0);
        tick(); check("live_seq_pc", 64'(bus.pc), 64'hA04);

        // Reset while a redirect is pending discards it
        bus.pc_en = 1'b0; set_br(1'b1, 32'h80);
        tick(); set_br(1'b0, 32'h0); reset = 1'b1;
        tick(); check("rst2_pc", 64'(bus.pc), 64'h0); check("rst2_pending", 64'(bus.redirect_pending), 64'h0);
        check("rst2_epoch", 64'(bus.epoch), 64'h0);
        reset = 1'b0; bus.pc_en = 1'b1;
        tick(); check("rst2_boot_pc", 64'(bus.pc), 64'h0);
        tick(); check("rst2_seq_pc", 64'(bus.pc), 64'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
